// File: rtl/cmds_scan_mc_pkg.sv
// cmds_scan_pkg: scanner state encoding, per-channel result codes and default execute opcode.
package cmds_scan_pkg;
    typedef enum logic [2:0] {IDLE, SEL, RD, DRAIN, DEC, EXEC, WB, DONE} state_t;
    localparam logic [1:0] ST_COPY = 2'b00;
    localparam logic [1:0] ST_OK = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;
    localparam logic [7:0] DO_CMD_DEF = 8'h01;
endpackage

// File: rtl/cmds_scan_mc_if.sv
// cmds_scan_mc_if: scan control, CDCB/CUCB buffer ports and executor handshake of the scanner.
interface cmds_scan_mc_if #(parameter int AW = 12, DW = 8, NUM_CH = 4);
    logic i_start_scan;
    logic [NUM_CH-1:0] im_ch_mask;
    logic [NUM_CH*AW-1:0] im_base_addr;
    logic o_busy;
    logic o_done_scan;
    logic [2*NUM_CH-1:0] om_status;
    logic [AW-1:0] om_cdcb_addr;
    logic [DW-1:0] im_cdcb_dout;
    logic o_cucb_wren;
    logic [AW-1:0] om_cucb_addr;
    logic [DW-1:0] om_cucb_din;
    logic o_start_con;
    logic [AW-1:0] om_base_addr;
    logic i_done_con;
    logic i_error_con;
    modport master (
        input i_start_scan, im_ch_mask, im_base_addr, im_cdcb_dout, i_done_con, i_error_con,
        output o_busy, o_done_scan, om_status, om_cdcb_addr, o_cucb_wren, om_cucb_addr,
        om_cucb_din, o_start_con, om_base_addr
    );
    modport slave (
        output i_start_scan, im_ch_mask, im_base_addr, im_cdcb_dout, i_done_con, i_error_con,
        input o_busy, o_done_scan, om_status, om_cdcb_addr, o_cucb_wren, om_cucb_addr,
        om_cucb_din, o_start_con, om_base_addr
    );
endinterface

// File: rtl/cmds_scan_mc_watchdog.sv
// cmds_exec_watchdog: counts enabled cycles since clear and flags the TIMEOUT-th one.
module cmds_exec_watchdog #(parameter int TIMEOUT = 1000) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
    assign expired = en && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/cmds_scan_mc.sv
// cmds_scan_mc: walks masked CDCB channel records, runs executor commands, copies records to CUCB.
module cmds_scan_mc import cmds_scan_pkg::*; #(
    parameter int AW = 12,
    parameter int DW = 8,
    parameter int REC_LEN = 8,
    parameter int NUM_CH = 4,
    parameter int RD_LAT = 2,
    parameter int EXEC_BASE = 56,
    parameter logic [DW-1:0] DO_CMD = DW'(DO_CMD_DEF),
    parameter int TIMEOUT = 1000
) (
    input logic clk,
    input logic rst,
    cmds_scan_mc_if.master bus
);
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int IW = $clog2(REC_LEN);
    localparam int CW = $clog2(REC_LEN + RD_LAT + 1);
    state_t state;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH*AW-1:0] bases;
    logic [AW-1:0] base;
    logic [CHW-1:0] ch, low;
    logic [CW-1:0] cnt;
    logic [IW-1:0] cap;
    logic [RD_LAT-1:0] vp;
    logic [DW-1:0] rec [REC_LEN];
    logic expired;
    always_comb begin
        low = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) if (pend[k]) low = CHW'(k);
    end
    cmds_exec_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk(clk), .rst(rst), .clr(state != EXEC), .en(state == EXEC), .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend <= '0;
            bases <= '0;
            base <= '0;
            ch <= '0;
            cnt <= '0;
            cap <= '0;
            vp <= '0;
            for (int i = 0; i < REC_LEN; i++) rec[i] <= '0;
            bus.o_busy <= 1'b0;
            bus.o_done_scan <= 1'b0;
            bus.om_status <= '0;
            bus.om_cdcb_addr <= '0;
            bus.o_cucb_wren <= 1'b0;
            bus.om_cucb_addr <= '0;
            bus.om_cucb_din <= '0;
            bus.o_start_con <= 1'b0;
            bus.om_base_addr <= '0;
        end else begin
            // each issued read tags its byte RD_LAT cycles later; bytes land in issue order
            vp <= (vp << 1) | RD_LAT'(state == RD);
            if (vp[RD_LAT-1]) begin
                rec[cap] <= bus.im_cdcb_dout;
                cap <= cap + 1'b1;
            end
            bus.o_start_con <= 1'b0;
            case (state)
                IDLE: if (bus.i_start_scan) begin
                    pend <= bus.im_ch_mask;
                    bases <= bus.im_base_addr;
                    bus.om_status <= {NUM_CH{ST_COPY}};
                    bus.o_busy <= 1'b1;
                    state <= SEL;
                end
                SEL: if (pend == '0) begin
                    bus.o_done_scan <= 1'b1;
                    state <= DONE;
                end else begin
                    ch <= low;
                    pend <= pend & (pend - 1'b1);
                    base <= bases[low*AW +: AW];
                    bus.om_cdcb_addr <= bases[low*AW +: AW];
                    cnt <= '0;
                    cap <= '0;
                    state <= RD;
                end
                RD: if (cnt == CW'(REC_LEN - 1)) begin
                    cnt <= '0;
                    state <= DRAIN;
                end else begin
                    cnt <= cnt + 1'b1;
                    bus.om_cdcb_addr <= bus.om_cdcb_addr + 1'b1;
                end
                DRAIN: if (cnt == CW'(RD_LAT - 1)) begin
                    cnt <= '0;
                    state <= DEC;
                end else cnt <= cnt + 1'b1;
                DEC: if (32'(base) >= EXEC_BASE && rec[0] == DO_CMD) begin
                    bus.o_start_con <= 1'b1;
                    bus.om_base_addr <= base;
                    state <= EXEC;
                end else begin
                    bus.o_cucb_wren <= 1'b1;
                    bus.om_cucb_addr <= base;
                    bus.om_cucb_din <= rec[0];
                    cnt <= '0;
                    state <= WB;
                end
                // a response in the expiry cycle still counts; error beats done
                EXEC: if (bus.i_error_con) begin
                    bus.om_status[2*ch +: 2] <= ST_ERR;
                    state <= SEL;
                end else if (bus.i_done_con) begin
                    bus.om_status[2*ch +: 2] <= ST_OK;
                    bus.o_cucb_wren <= 1'b1;
                    bus.om_cucb_addr <= base;
                    bus.om_cucb_din <= rec[0];
                    cnt <= '0;
                    state <= WB;
                end else if (expired) begin
                    bus.om_status[2*ch +: 2] <= ST_TMO;
                    state <= SEL;
                end
                WB: if (cnt == CW'(REC_LEN - 1)) begin
                    bus.o_cucb_wren <= 1'b0;
                    bus.om_cucb_addr <= '0;
                    bus.om_cucb_din <= '0;
                    state <= SEL;
                end else begin
                    cnt <= cnt + 1'b1;
                    bus.om_cucb_addr <= bus.om_cucb_addr + 1'b1;
                    bus.om_cucb_din <= rec[IW'(cnt + 1'b1)];
                end
                DONE: begin
                    bus.o_done_scan <= 1'b0;
                    bus.o_busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmds_scan_mc.sv
// tb_cmds_scan_mc: directed scans of cmds_scan_mc against a CDCB model and hand-computed results.
module tb_cmds_scan_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, n_cmp = 0, n_err = 0;
    int nw = 0, n_done = 0, n_start = 0, n_dinbad = 0;
    int t0, tx, ts;
    bit hit;
    logic [11:0] wa [64];
    logic [7:0] wd [64];
    int wc [64];
    logic [7:0] mem [4096];
    logic [7:0] p0 = '0, p1 = '0;
    logic [11:0] ea;

    cmds_scan_mc_if bus();
    cmds_scan_mc #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        p0 <= mem[bus.om_cdcb_addr];
        p1 <= p0;
    end
    assign bus.im_cdcb_dout = p1;

    always @(negedge clk) begin
        if (bus.o_cucb_wren && nw < 64) begin
            wa[nw] = bus.om_cucb_addr;
            wd[nw] = bus.om_cucb_din;
            wc[nw] = cyc;
            nw++;
        end
        if (!bus.o_cucb_wren && bus.om_cucb_din !== 8'h00) n_dinbad++;
        if (bus.o_done_scan) n_done++;
        if (bus.o_start_con) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] m, input logic [47:0] b);
        nw = 0;
        n_done = 0;
        n_start = 0;
        @(negedge clk);
        bus.im_ch_mask = m;
        bus.im_base_addr = b;
        bus.i_start_scan = 1'b1;
        @(negedge clk);
        bus.i_start_scan = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_sig(input bit want_done, input int budget, output int t);
        hit = 0;
        t = -1;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (want_done ? bus.o_done_scan : bus.o_start_con) begin
                hit = 1;
                t = cyc;
            end
        end
    endtask

    initial begin
        bus.i_start_scan = 1'b0;
        bus.im_ch_mask = '0;
        bus.im_base_addr = '0;
        bus.i_done_con = 1'b0;
        bus.i_error_con = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        mem[56] = 8'h01;
        for (int i = 1; i < 8; i++) mem[56+i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 8; i++) mem[100+i] = 8'hB0 + 8'(i);
        mem[200] = 8'h01;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done_scan, 0);
        chk("rst_status", bus.om_status, 0);
        chk("rst_wren", bus.o_cucb_wren, 0);
        chk("rst_din", bus.om_cucb_din, 0);
        chk("rst_start_con", bus.o_start_con, 0);
        chk("rst_cdcb_addr", bus.om_cdcb_addr, 0);
        chk("rst_cucb_addr", bus.om_cucb_addr, 0);
        chk("rst_base_addr", bus.om_base_addr, 0);
        rst = 1'b0;

        // plain copy of channel 0, with a second start issued mid-scan
        start(4'b0001, 48'h0);
        chk("copy_busy", bus.o_busy, 1);
        repeat (5) @(negedge clk);
        bus.im_ch_mask = 4'b1111;
        bus.i_start_scan = 1'b1;
        @(negedge clk);
        bus.i_start_scan = 1'b0;
        wait_sig(1, 60, tx);
        chk("copy_done_t", tx, t0 + 21);
        @(negedge clk);
        chk("copy_nw", nw, 8);
        for (int i = 0; i < 8; i++) begin
            chk("copy_addr", wa[i], i);
            chk("copy_data", wd[i], 8'h10 + i);
            chk("copy_cyc", wc[i], t0 + 12 + i);
        end
        chk("copy_status", bus.om_status, 0);
        chk("copy_ndone", n_done, 1);
        chk("copy_nstart", n_start, 0);
        chk("copy_idle", bus.o_busy, 0);

        // executor success on channel 1, response five cycles after the start pulse
        start(4'b0010, {12'd0, 12'd0, 12'd56, 12'd0});
        wait_sig(0, 40, ts);
        chk("exok_start_t", ts, t0 + 12);
        chk("exok_base", bus.om_base_addr, 56);
        repeat (5) @(negedge clk);
        bus.i_done_con = 1'b1;
        @(negedge clk);
        bus.i_done_con = 1'b0;
        wait_sig(1, 60, tx);
        chk("exok_done_t", tx, t0 + 27);
        @(negedge clk);
        chk("exok_nw", nw, 8);
        chk("exok_addr0", wa[0], 56);
        chk("exok_data0", wd[0], 8'h01);
        chk("exok_data7", wd[7], 8'hA7);
        chk("exok_addr7", wa[7], 63);
        chk("exok_wb_t", wc[0], t0 + 18);
        chk("exok_status", bus.om_status, 8'h04);
        chk("exok_nstart", n_start, 1);

        // error together with done on channel 0; channel 1 still copied
        start(4'b0011, {12'd0, 12'd0, 12'd100, 12'd56});
        wait_sig(0, 40, ts);
        chk("err_start_t", ts, t0 + 12);
        repeat (2) @(negedge clk);
        bus.i_error_con = 1'b1;
        bus.i_done_con = 1'b1;
        @(negedge clk);
        bus.i_error_con = 1'b0;
        bus.i_done_con = 1'b0;
        wait_sig(1, 80, tx);
        chk("err_done_t", tx, t0 + 36);
        @(negedge clk);
        chk("err_status", bus.om_status, 8'h02);
        chk("err_nw", nw, 8);
        chk("err_addr0", wa[0], 100);
        chk("err_data0", wd[0], 8'hB0);
        chk("err_addr7", wa[7], 107);
        chk("err_ndone", n_done, 1);
        chk("err_nstart", n_start, 1);

        // silent executor on channel 2
        start(4'b0100, {12'd0, 12'd200, 12'd0, 12'd0});
        wait_sig(0, 40, ts);
        chk("tmo_start_t", ts, t0 + 12);
        wait_sig(1, 60, tx);
        chk("tmo_done_t", tx, ts + 17);
        @(negedge clk);
        chk("tmo_status", bus.om_status, 8'h30);
        chk("tmo_nw", nw, 0);
        chk("tmo_nstart", n_start, 1);

        // done arriving in the expiry cycle wins over the timeout
        start(4'b0100, {12'd0, 12'd200, 12'd0, 12'd0});
        wait_sig(0, 40, ts);
        repeat (15) @(negedge clk);
        bus.i_done_con = 1'b1;
        @(negedge clk);
        bus.i_done_con = 1'b0;
        wait_sig(1, 60, tx);
        chk("late_done_t", tx, ts + 25);
        @(negedge clk);
        chk("late_status", bus.om_status, 8'h10);
        chk("late_nw", nw, 8);
        chk("late_wb_t", wc[0], ts + 16);

        // record straddling the top of the address space
        for (int i = 0; i < 4; i++) mem[12'hFFC + i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 4; i++) mem[i] = 8'hC4 + 8'(i);
        start(4'b1000, {12'hFFC, 12'd0, 12'd0, 12'd0});
        wait_sig(1, 60, tx);
        chk("wrap_done_t", tx, t0 + 21);
        @(negedge clk);
        chk("wrap_nw", nw, 8);
        for (int i = 0; i < 8; i++) begin
            ea = 12'hFFC + 12'(i);
            chk("wrap_addr", wa[i], ea);
            chk("wrap_data", wd[i], 8'hC0 + i);
        end
        chk("wrap_status", bus.om_status, 0);
        chk("wrap_nstart", n_start, 0);

        // empty mask
        start(4'b0000, 48'h0);
        wait_sig(1, 10, tx);
        chk("empty_done_t", tx, t0 + 1);
        @(negedge clk);
        chk("empty_nw", nw, 0);
        chk("empty_idle", bus.o_busy, 0);

        // reset during writeback, then a fresh scan
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        start(4'b0001, 48'h0);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.o_cucb_wren) hit = 1;
        end
        chk("rwb_reached_wb", hit, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rwb_busy", bus.o_busy, 0);
        chk("rwb_wren", bus.o_cucb_wren, 0);
        chk("rwb_din", bus.om_cucb_din, 0);
        chk("rwb_cucb_addr", bus.om_cucb_addr, 0);
        chk("rwb_cdcb_addr", bus.om_cdcb_addr, 0);
        chk("rwb_done", bus.o_done_scan, 0);
        chk("rwb_status", bus.om_status, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rwb_no_done", n_done, 0);
        start(4'b0001, 48'h0);
        wait_sig(1, 60, tx);
        chk("rwb_fresh_done_t", tx, t0 + 21);
        @(negedge clk);
        chk("rwb_fresh_nw", nw, 8);
        chk("rwb_fresh_data7", wd[7], 8'h17);
        chk("rwb_fresh_ndone", n_done, 1);
        chk("din_zero_idle", n_dinbad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cmds_scan_mc.md
# cmds_scan_mc

Multi-channel, parametrised command scanner for the control-station console path. On a scan request it walks a masked set of channel records in the command-down buffer (CDCB) and reads each fixed-length record. Executor-class records that carry the execute opcode are handed to the command executor under a watchdog. Completed records are copied to the command-up buffer (CUCB), and a per-channel result code is reported. Unlike the single-record scanner, a failing channel does not abort the scan; the block records the failure and moves to the next channel.

## Interface
- AW, 12: CDCB/CUCB address width.
- DW, 8: data byte width.
- REC_LEN, 8: bytes per command record (≥2).
- NUM_CH, 4: channel count.
- RD_LAT, 2: CDCB read latency in cycles (≥1).
- EXEC_BASE, 56: base addresses ≥ this are executor-class.
- DO_CMD, 8'h01: execute opcode, byte 0 of the record.
- TIMEOUT, 1000: executor watchdog limit in cycles (≥1).
- clk, in, 1: sole clock.
- rst, in, 1: reset, synchronous, active-high.
- i_start_scan, in, 1: scan request; sampled in IDLE only.
- im_ch_mask, in, NUM_CH: channels to scan; latched with start.
- im_base_addr, in, NUM_CH*AW: flat base addresses; channel k is at [k*AW +: AW]; latched with start.
- o_busy, out, 1: high in every state except IDLE.
- o_done_scan, out, 1: one-cycle completion pulse.
- om_status, out, 2*NUM_CH: per-channel result at [2k +: 2]. Codes: 00 copied/not scanned, 01 executed OK, 10 executor error, 11 timeout.
- om_cdcb_addr, out, AW: CDCB read address.
- im_cdcb_dout, in, DW: CDCB read data, valid RD_LAT cycles after its address.
- o_cucb_wren, out, 1: CUCB write enable.
- om_cucb_addr, out, AW: CUCB write address.
- om_cucb_din, out, DW: CUCB write data; 0 when o_cucb_wren=0.
- o_start_con, out, 1: one-cycle executor start pulse.
- om_base_addr, out, AW: record base handed to the executor.
- i_done_con, in, 1: executor success.
- i_error_con, in, 1: executor failure.

## Operation
- Reset: state IDLE. All outputs, om_status, the pending mask, the record buffer and the capture pipe are cleared to 0. Reset mid-scan aborts with no done pulse.
- IDLE: when i_start_scan=1, latch mask and bases, clear om_status, and go to SEL.
- SEL: if the pending mask is empty, go to DONE. Otherwise take the lowest set channel k, clear its pending bit, drive om_cdcb_addr to base_k, and go to RD.
- RD: lasts REC_LEN cycles. The address is base_k+i in cycle i and increments mod 2^AW. After the last address, go to DRAIN.
- Capture: a valid bit delayed RD_LAT stages tags each returning byte, which is stored into rec[i] in order.
- DRAIN: lasts RD_LAT cycles, then go to DEC.
- DEC: if base_k ≥ EXEC_BASE and rec[0]==DO_CMD, pulse o_start_con, set om_base_addr=base_k, and go to EXEC. Otherwise go to WB.
- EXEC: the watchdog counts from the cycle after the start pulse.
  - i_error_con=1: status_k=10, go to SEL with no writeback.
  - i_done_con=1 (and no error): status_k=01, go to WB.
  - TIMEOUT cycles elapse with no response: status_k=11, go to SEL.
  - Error has priority when error and done arrive together.
  - A response arriving in the same cycle as expiry wins over the timeout.
- WB: lasts REC_LEN cycles with o_cucb_wren=1. The address is base_k+i (mod 2^AW) and the data is rec[i]. Then go to SEL.
- DONE: o_done_scan=1 for one cycle, then go to IDLE.
- i_start_scan outside IDLE is ignored. Executor inputs outside EXEC are ignored.

## Timing
- All outputs are registered.
- Per copied channel: 1 (SEL) + REC_LEN + RD_LAT + 1 (DEC) + REC_LEN cycles. With defaults this is 20.
- Executed channel: the copy time plus the EXEC dwell. EXEC dwell is response latency + 1 cycle.
- Empty mask: start sampled at T, SEL at T+1, o_done_scan high at T+2.
- A new start is accepted the cycle after the DONE pulse.

## Structure
- Package cmds_scan_pkg holds the state enumeration (IDLE, SEL, RD, DRAIN, DEC, EXEC, WB, DONE), the status codes ST_COPY/ST_OK/ST_ERR/ST_TMO, and the default DO_CMD.
- One sub-module, cmds_exec_watchdog: clear/enable inputs, TIMEOUT parameter, expired output.
- The priority encoder for the lowest pending channel stays inline.

## Test plan
- Copy path: mask=4'b0001, base0=12'd0, CDCB[0..7]=8'h10..8'h17, start at T. Required: CUCB writes addr 0..7 = 8'h10..8'h17 in T+13..T+20, done pulse at T+22, om_status=0.
- Executed OK: mask=4'b0010, base1=12'd56, CDCB[56]=8'h01. Required: one o_start_con with om_base_addr=56. Executor returns done 5 cycles later; then the record is written back and status[3:2]=01.
- Error plus continue: mask=4'b0011, ch0 executor-class with DO_CMD, i_error_con and i_done_con together. Required: ch0 status=10 with no ch0 writeback; ch1 is still copied; a single done pulse.
- Timeout: TIMEOUT=16, executor silent. Required: status=11 after exactly 16 EXEC cycles, no writeback.
- Edges: base=12'hFFC copies across the wrap (addresses FFC..FFF, 000..003). Empty mask gives done at T+2. A start during busy is ignored.
- Reset in WB: every output is 0 the next cycle, no done pulse, and a fresh scan runs normally afterwards.
